// File: rtl/smpc_pad_scan.sv
// Four-phase Saturn digital pad scanner. Drives TH/TR, samples one nibble per phase,
// and assembles the active-low JOY1 button word for the SMPC.
module smpc_pad_scan #(
  parameter int SETTLE = 32
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE,
  input  logic        SCAN_REQ,
  input  logic [6:0]  PI,
  output logic [6:0]  PO,
  output logic        BUSY,
  output logic        VALID,
  output logic        PRESENT,
  output logic [15:0] JOY
);
  typedef enum logic [2:0] {IDLE, PH0, PH1, PH2, PH3, DONE} state_t;

  localparam logic [7:0] RELOAD = 8'(SETTLE - 1);
  localparam logic [2:0] PAD_ID = 3'b100;

  state_t          state, state_nx;
  logic [7:0]      cnt;
  logic [3:0][3:0] nib;
  logic [1:0]      ph;
  logic            in_phase;
  logic [15:0]     joy_asm;
  logic            unused_pins;

  assign unused_pins = ^PI[6:4];

  always_ff @(posedge CLK) begin
    if (RST)     state <= IDLE;
    else if (CE) state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (SCAN_REQ) state_nx = PH0;
      PH0:     if (cnt == 8'd0) state_nx = PH1;
      PH1:     if (cnt == 8'd0) state_nx = PH2;
      PH2:     if (cnt == 8'd0) state_nx = PH3;
      PH3:     if (cnt == 8'd0) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // PO is a pure decode of the state register, so PI never reaches it.
  always_comb begin
    ph       = 2'd0;
    in_phase = 1'b0;
    case (state)
      PH0:     begin ph = 2'd0; in_phase = 1'b1; end
      PH1:     begin ph = 2'd1; in_phase = 1'b1; end
      PH2:     begin ph = 2'd2; in_phase = 1'b1; end
      PH3:     begin ph = 2'd3; in_phase = 1'b1; end
      default: begin ph = 2'd0; in_phase = 1'b0; end
    endcase
    PO   = 7'b1100000;
    if (in_phase) PO[6:5] = ph;
    BUSY = (state != IDLE);
  end

  assign joy_asm = {nib[2][0], nib[2][1], nib[2][2], nib[2][3],
                    nib[1][0], nib[1][1], nib[1][2], nib[1][3],
                    nib[0][0], nib[0][1], nib[0][2], nib[0][3],
                    nib[3][3], 3'b111};

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt     <= 8'd0;
      nib     <= '1;
      JOY     <= 16'hFFFF;
      PRESENT <= 1'b0;
      VALID   <= 1'b0;
    end else begin
      VALID <= 1'b0;
      if (CE) begin
        if (state == IDLE) begin
          if (SCAN_REQ) cnt <= RELOAD;
        end else if (in_phase) begin
          if (cnt == 8'd0) begin
            nib[ph] <= PI[3:0];
            cnt     <= RELOAD;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end else if (state == DONE) begin
          // Anything other than the digital pad ID reads as "no buttons".
          if (nib[3][2:0] == PAD_ID) begin
            PRESENT <= 1'b1;
            JOY     <= joy_asm;
          end else begin
            PRESENT <= 1'b0;
            JOY     <= 16'hFFFF;
          end
          VALID <= 1'b1;
        end
      end
    end
  end
endmodule
